packet_framer: RTL and testbench

Upstream framing stage for the packet parser. Accepts a packet-length command and a raw word stream over valid/ready handshakes, and emits a registered stream with `data_valid`, `start_of_packet` and `end_of_packet` markers. An abort input truncates a packet, which lets the system deliberately inject short packets into the parser. A saturating counter tracks transmitted packets.

---
 rtl/packet_framer.sv | 95 +++++++++
 tb/tb_packet_framer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// packet_framer: turns a packet-length command plus a raw word stream into a
// registered, framed stream with SOP/EOP markers, abort truncation and a packet counter.
module packet_framer #(
  parameter int PACKET_WIDTH = 32,
  parameter int MAX_LEN      = 7,
  parameter int LEN_W        = $clog2(MAX_LEN + 1),
  parameter int MAX_COUNT    = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  input  logic [LEN_W-1:0]                 cmd_len,
  output logic                             cmd_ready,
  input  logic                             in_valid,
  input  logic [PACKET_WIDTH-1:0]          in_data,
  input  logic                             abort,
  output logic                             in_ready,
  output logic                             data_valid,
  output logic [PACKET_WIDTH-1:0]          packet_data_out,
  output logic                             start_of_packet,
  output logic                             end_of_packet,
  output logic                             len_error_flag,
  output logic [$clog2(MAX_COUNT+1)-1:0]   tx_packet_counter
);

  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_W-1:0] MAX_CNT_V = CNT_W'(MAX_COUNT);

  logic [0:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic             cmd_fire;
  logic             word_fire;
  logic             len_bad;
  logic             last_word;

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == SEND);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign word_fire = in_valid & in_ready;
  assign len_bad   = (cmd_len == '0) || (int'(cmd_len) > MAX_LEN);
  // Abort only matters when paired with an accepted word (gated by word_fire below).
  assign last_word = (word_cnt == len_q - LEN_W'(1)) || abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      len_q             <= '0;
      word_cnt          <= '0;
      data_valid        <= 1'b0;
      packet_data_out   <= '0;
      start_of_packet   <= 1'b0;
      end_of_packet     <= 1'b0;
      len_error_flag    <= 1'b0;
      tx_packet_counter <= '0;
    end else begin
      data_valid      <= 1'b0;
      start_of_packet <= 1'b0;
      end_of_packet   <= 1'b0;
      len_error_flag  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (len_bad) begin
              len_error_flag <= 1'b1;
            end else begin
              len_q    <= cmd_len;
              word_cnt <= '0;
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (word_fire) begin
            data_valid      <= 1'b1;
            packet_data_out <= in_data;
            start_of_packet <= (word_cnt == '0);
            end_of_packet   <= last_word;
            word_cnt        <= word_cnt + LEN_W'(1);
            if (last_word) begin
              state <= IDLE;
              if (tx_packet_counter != MAX_CNT_V) begin
                tx_packet_counter <= tx_packet_counter + CNT_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Directed, table-driven bench for packet_framer with hand-written sequences for
// counter saturation and reset in the middle of a packet.
module tb_packet_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_len = '0;
  logic        cmd_ready;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        abort = 1'b0;
  logic        in_ready;
  logic        data_valid;
  logic [31:0] packet_data_out;
  logic        start_of_packet;
  logic        end_of_packet;
  logic        len_error_flag;
  logic [3:0]  tx_packet_counter;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        cv;
    logic [2:0]  cl;
    logic        iv;
    logic [31:0] d;
    logic        ab;
    logic        e_dv;
    logic        e_sop;
    logic        e_eop;
    logic [31:0] e_d;
    logic        e_cr;
    logic        e_ir;
    logic        e_err;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  packet_framer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_data(in_data), .abort(abort), .in_ready(in_ready),
    .data_valid(data_valid), .packet_data_out(packet_data_out),
    .start_of_packet(start_of_packet), .end_of_packet(end_of_packet),
    .len_error_flag(len_error_flag), .tx_packet_counter(tx_packet_counter)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int cv, int cl, int iv, logic [31:0] d, int ab,
                              int dv, int sop, int eop, logic [31:0] ed,
                              int cr, int ir, int err, int cnt);
    vec_t v;
    v.cv = 1'(cv);   v.cl = 3'(cl);     v.iv = 1'(iv);    v.d = d;     v.ab = 1'(ab);
    v.e_dv = 1'(dv); v.e_sop = 1'(sop); v.e_eop = 1'(eop); v.e_d = ed;
    v.e_cr = 1'(cr); v.e_ir = 1'(ir);   v.e_err = 1'(err); v.e_cnt = 4'(cnt);
    return v;
  endfunction

  task automatic add(vec_t v);
    vecs.push_back(v);
  endtask

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    cmd_valid = v.cv;
    cmd_len   = v.cl;
    in_valid  = v.iv;
    in_data   = v.d;
    abort     = v.ab;
  endtask

  task automatic checkOutput(string tag, vec_t v);
    compare({tag, " data_valid"},      32'(data_valid),        32'(v.e_dv));
    compare({tag, " sop"},             32'(start_of_packet),   32'(v.e_sop));
    compare({tag, " eop"},             32'(end_of_packet),     32'(v.e_eop));
    compare({tag, " data"},            packet_data_out,        v.e_d);
    compare({tag, " cmd_ready"},       32'(cmd_ready),         32'(v.e_cr));
    compare({tag, " in_ready"},        32'(in_ready),          32'(v.e_ir));
    compare({tag, " len_error_flag"},  32'(len_error_flag),    32'(v.e_err));
    compare({tag, " counter"},         32'(tx_packet_counter), 32'(v.e_cnt));
  endtask

  initial begin
    logic [31:0] last_d;
    int          model_cnt;

    // Expected values describe the outputs one cycle after the row's inputs are applied.
    //      cv cl iv data     ab   dv sop eop data     cr ir er cnt
    add(mk(1, 5, 0, 32'h0,  0,   0, 0, 0, 32'h0,  0, 1, 0, 0));
    add(mk(0, 0, 1, 32'hA0, 0,   1, 1, 0, 32'hA0, 0, 1, 0, 0));
    add(mk(0, 0, 1, 32'hA1, 0,   1, 0, 0, 32'hA1, 0, 1, 0, 0));
    add(mk(0, 0, 1, 32'hA2, 0,   1, 0, 0, 32'hA2, 0, 1, 0, 0));
    add(mk(0, 0, 1, 32'hA3, 0,   1, 0, 0, 32'hA3, 0, 1, 0, 0));
    add(mk(0, 0, 1, 32'hA4, 0,   1, 0, 1, 32'hA4, 1, 0, 0, 1));
    add(mk(0, 0, 0, 32'h0,  0,   0, 0, 0, 32'hA4, 1, 0, 0, 1));
    add(mk(1, 3, 0, 32'h0,  0,   0, 0, 0, 32'hA4, 0, 1, 0, 1));
    add(mk(0, 0, 1, 32'hB0, 0,   1, 1, 0, 32'hB0, 0, 1, 0, 1));
    add(mk(0, 0, 0, 32'h0,  0,   0, 0, 0, 32'hB0, 0, 1, 0, 1));
    add(mk(0, 0, 1, 32'hB1, 0,   1, 0, 0, 32'hB1, 0, 1, 0, 1));
    add(mk(0, 0, 0, 32'h0,  0,   0, 0, 0, 32'hB1, 0, 1, 0, 1));
    add(mk(0, 0, 1, 32'hB2, 0,   1, 0, 1, 32'hB2, 1, 0, 0, 2));
    add(mk(1, 1, 0, 32'h0,  0,   0, 0, 0, 32'hB2, 0, 1, 0, 2));
    add(mk(0, 0, 1, 32'hC0, 0,   1, 1, 1, 32'hC0, 1, 0, 0, 3));
    add(mk(1, 5, 0, 32'h0,  0,   0, 0, 0, 32'hC0, 0, 1, 0, 3));
    add(mk(0, 0, 1, 32'hD0, 0,   1, 1, 0, 32'hD0, 0, 1, 0, 3));
    add(mk(0, 0, 0, 32'h0,  1,   0, 0, 0, 32'hD0, 0, 1, 0, 3));
    add(mk(0, 0, 1, 32'hD1, 0,   1, 0, 0, 32'hD1, 0, 1, 0, 3));
    add(mk(0, 0, 1, 32'hD2, 1,   1, 0, 1, 32'hD2, 1, 0, 0, 4));
    add(mk(0, 0, 1, 32'hD3, 1,   0, 0, 0, 32'hD2, 1, 0, 0, 4));
    add(mk(1, 0, 0, 32'h0,  0,   0, 0, 0, 32'hD2, 1, 0, 1, 4));
    add(mk(0, 0, 0, 32'h0,  0,   0, 0, 0, 32'hD2, 1, 0, 0, 4));
    add(mk(1, 4, 0, 32'h0,  0,   0, 0, 0, 32'hD2, 0, 1, 0, 4));
    add(mk(0, 0, 1, 32'hE0, 1,   1, 1, 1, 32'hE0, 1, 0, 0, 5));
    add(mk(1, 2, 0, 32'h0,  0,   0, 0, 0, 32'hE0, 0, 1, 0, 5));
    add(mk(1, 3, 1, 32'hF0, 0,   1, 1, 0, 32'hF0, 0, 1, 0, 5));
    add(mk(1, 3, 1, 32'hF1, 0,   1, 0, 1, 32'hF1, 1, 0, 0, 6));
    add(mk(1, 1, 0, 32'h0,  0,   0, 0, 0, 32'hF1, 0, 1, 0, 6));
    add(mk(0, 0, 1, 32'h70, 0,   1, 1, 1, 32'h70, 1, 0, 0, 7));
    add(mk(1, 7, 0, 32'h0,  0,   0, 0, 0, 32'h70, 0, 1, 0, 7));
    add(mk(0, 0, 1, 32'h71, 1,   1, 1, 1, 32'h71, 1, 0, 0, 8));

    repeat (2) @(negedge clk);
    checkOutput("reset_held", mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_released", mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d", i), vecs[i]);
    end

    model_cnt = 8;
    last_d    = 32'h71;
    for (int p = 0; p < 17; p++) begin
      applyStimulus(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, last_d, 0, 1, 0, model_cnt));
      @(negedge clk);
      checkOutput($sformatf("sat%0d_cmd", p), mk(1, 1, 0, 32'h0, 0, 0, 0, 0, last_d, 0, 1, 0, model_cnt));
      model_cnt = (model_cnt < 15) ? model_cnt + 1 : 15;
      last_d    = 32'h100 + 32'(p);
      applyStimulus(mk(0, 0, 1, last_d, 0, 1, 1, 1, last_d, 1, 0, 0, model_cnt));
      @(negedge clk);
      checkOutput($sformatf("sat%0d_word", p), mk(0, 0, 1, last_d, 0, 1, 1, 1, last_d, 1, 0, 0, model_cnt));
    end
    compare("saturated counter", 32'(tx_packet_counter), 32'd15);

    applyStimulus(mk(1, 3, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    applyStimulus(mk(0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("mid_word1", mk(0, 0, 1, 32'h200, 0, 1, 1, 0, 32'h200, 0, 1, 0, 15));
    applyStimulus(mk(0, 0, 1, 32'h201, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #1 checkOutput("mid_reset", mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset%0d", c), mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
